dkong3_snd_cmd_seq: RTL and testbench



---
 rtl/dkong3_snd_cmd_seq_if.sv | 24 ++
 rtl/dkong3_snd_cmd_seq.sv | 113 +++++++++++
 tb/tb_dkong3_snd_cmd_seq.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/dkong3_snd_cmd_seq_if.sv
// dkong3_snd_cmd_seq_if: main-CPU write port and sound-board latch bus of the command sequencer
interface dkong3_snd_cmd_seq_if #(
    parameter int DEPTH_LOG2 = 2
);
    logic                  I_WR;
    logic [1:0]            I_PORT;
    logic [7:0]            I_DATA;
    logic [7:0]            O_MCPU_DO;
    logic [3:0]            O_4E_Q;
    logic                  O_BUSY;
    logic [DEPTH_LOG2:0]   O_LEVEL;
    logic                  O_OVF;
    logic                  O_BADPORT;

    modport master (
        output I_WR, I_PORT, I_DATA,
        input  O_MCPU_DO, O_4E_Q, O_BUSY, O_LEVEL, O_OVF, O_BADPORT
    );

    modport slave (
        input  I_WR, I_PORT, I_DATA,
        output O_MCPU_DO, O_4E_Q, O_BUSY, O_LEVEL, O_OVF, O_BADPORT
    );
endinterface

// File: rtl/dkong3_snd_cmd_seq.sv
// dkong3_snd_cmd_seq: queues sound-command writes and replays them with setup/strobe/hold timing
module dkong3_snd_cmd_seq #(
    parameter int DEPTH_LOG2 = 2,
    parameter int SETUP_CYC  = 2,
    parameter int STROBE_CYC = 4,
    parameter int HOLD_CYC   = 2
) (
    input logic                 I_SUBCLK,
    input logic                 I_SUB_RESETn,
    dkong3_snd_cmd_seq_if.slave bus
);
    localparam int CW = $clog2(SETUP_CYC + STROBE_CYC + HOLD_CYC + 1);
    localparam logic [CW-1:0] SETUP_LD  = CW'(SETUP_CYC - 1);
    localparam logic [CW-1:0] STROBE_LD = CW'(STROBE_CYC - 1);
    localparam logic [CW-1:0] HOLD_LD   = CW'(HOLD_CYC - 1);

    typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

    state_t                st, st_n;
    logic [CW-1:0]         cnt, cnt_n;
    logic [7:0]            dout, dout_n;
    logic [1:0]            port_r, port_n;
    logic [3:0]            q_r, q_n;
    logic [DEPTH_LOG2:0]   wp, rp, wp_n, rp_n, lvl, lvl_n;
    logic                  ovf, bad, busy, ovf_n, bad_n, busy_n;
    logic                  full, empty, push, pop, valid_port;
    logic [9:0]            head;
    logic [9:0]            mem [2**DEPTH_LOG2];

    assign full       = (wp[DEPTH_LOG2] != rp[DEPTH_LOG2]) && (wp[DEPTH_LOG2-1:0] == rp[DEPTH_LOG2-1:0]);
    assign empty      = wp == rp;
    assign valid_port = bus.I_PORT != 2'd3;
    assign push       = bus.I_WR && valid_port && !full;
    assign pop        = (st == IDLE) && !empty;
    assign head       = mem[rp[DEPTH_LOG2-1:0]];

    // Next-state, pointer and flag computation; outputs are registered from these
    always_comb begin
        st_n   = st;
        cnt_n  = cnt;
        dout_n = dout;
        port_n = port_r;
        q_n    = q_r;
        case (st)
            IDLE:   if (!empty) begin
                        st_n   = SETUP;
                        cnt_n  = SETUP_LD;
                        dout_n = head[7:0];
                        port_n = head[9:8];
                    end
            SETUP:  if (cnt == '0) begin
                        st_n  = STROBE;
                        cnt_n = STROBE_LD;
                        q_n   = 4'b0001 << port_r;
                    end else cnt_n = cnt - 1'b1;
            STROBE: if (cnt == '0) begin
                        st_n  = HOLD;
                        cnt_n = HOLD_LD;
                        q_n   = 4'h0;
                    end else cnt_n = cnt - 1'b1;
            HOLD:   if (cnt == '0) st_n = IDLE;
                    else cnt_n = cnt - 1'b1;
            default: st_n = IDLE;
        endcase
        wp_n   = wp + {{DEPTH_LOG2{1'b0}}, push};
        rp_n   = rp + {{DEPTH_LOG2{1'b0}}, pop};
        lvl_n  = wp_n - rp_n;
        ovf_n  = ovf | (bus.I_WR && valid_port && full);
        bad_n  = bad | (bus.I_WR && !valid_port);
        busy_n = (st_n != IDLE) || (wp_n != rp_n);
    end

    // State, pointers, bus outputs and sticky flags
    always_ff @(posedge I_SUBCLK) begin
        if (!I_SUB_RESETn) begin
            st     <= IDLE;
            cnt    <= '0;
            dout   <= 8'h00;
            port_r <= 2'd0;
            q_r    <= 4'h0;
            wp     <= '0;
            rp     <= '0;
            lvl    <= '0;
            ovf    <= 1'b0;
            bad    <= 1'b0;
            busy   <= 1'b0;
        end else begin
            st     <= st_n;
            cnt    <= cnt_n;
            dout   <= dout_n;
            port_r <= port_n;
            q_r    <= q_n;
            wp     <= wp_n;
            rp     <= rp_n;
            lvl    <= lvl_n;
            ovf    <= ovf_n;
            bad    <= bad_n;
            busy   <= busy_n;
        end
    end

    // FIFO storage; contents are don't-care until written, so no reset
    always_ff @(posedge I_SUBCLK) begin
        if (push) mem[wp[DEPTH_LOG2-1:0]] <= {bus.I_PORT, bus.I_DATA};
    end

    assign bus.O_MCPU_DO = dout;
    assign bus.O_4E_Q    = q_r;
    assign bus.O_BUSY    = busy;
    assign bus.O_LEVEL   = lvl;
    assign bus.O_OVF     = ovf;
    assign bus.O_BADPORT = bad;
endmodule

// File: tb/tb_dkong3_snd_cmd_seq.sv
// tb_dkong3_snd_cmd_seq: directed checks of the sound-command sequencer at default and minimal timing
`define CHK(tag, obs, exp) begin checks++; assert ((obs) === (exp)) else begin errors++; $error("FAIL %s observed=%0h expected=%0h", tag, (obs), (exp)); end end

module tb_dkong3_snd_cmd_seq;
    typedef struct {
        logic [3:0] q;
        logic [7:0] d;
        int         t;
    } ev_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    int   pk;
    ev_t  log1[$];
    ev_t  log2[$];
    logic [3:0] q1p = 4'h0;
    logic [3:0] q2p = 4'h0;
    logic [7:0] bd[4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    logic [1:0] bp[4] = '{2'd0, 2'd1, 2'd2, 2'd0};
    logic [3:0] bq[4] = '{4'b0001, 4'b0010, 4'b0100, 4'b0001};

    dkong3_snd_cmd_seq_if #(.DEPTH_LOG2(2)) b1();
    dkong3_snd_cmd_seq_if #(.DEPTH_LOG2(2)) b2();

    dkong3_snd_cmd_seq #(.DEPTH_LOG2(2), .SETUP_CYC(2), .STROBE_CYC(4), .HOLD_CYC(2)) dut (
        .I_SUBCLK(clk), .I_SUB_RESETn(rst_n), .bus(b1.slave)
    );

    dkong3_snd_cmd_seq #(.DEPTH_LOG2(2), .SETUP_CYC(1), .STROBE_CYC(1), .HOLD_CYC(1)) dut_min (
        .I_SUBCLK(clk), .I_SUB_RESETn(rst_n), .bus(b2.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record each rising strobe with its data and cycle; the strobe must never have two bits high
    always @(negedge clk) begin
        if (rst_n && b1.O_4E_Q != 4'h0 && q1p == 4'h0) log1.push_back('{b1.O_4E_Q, b1.O_MCPU_DO, cyc});
        if (rst_n && b2.O_4E_Q != 4'h0 && q2p == 4'h0) log2.push_back('{b2.O_4E_Q, b2.O_MCPU_DO, cyc});
        if ($countones(b1.O_4E_Q) > 1) begin
            errors++;
            $error("FAIL onehot observed=%0h expected=at most one bit", b1.O_4E_Q);
        end
        q1p <= b1.O_4E_Q;
        q2p <= b2.O_4E_Q;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cyc(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        wait_cyc(2);
        rst_n = 1'b1;
        tick();
        log1.delete();
        log2.delete();
    endtask

    initial begin
        b1.I_WR = 1'b0; b1.I_PORT = 2'd0; b1.I_DATA = 8'h00;
        b2.I_WR = 1'b0; b2.I_PORT = 2'd0; b2.I_DATA = 8'h00;
        wait_cyc(2);
        `CHK("rst_do", b1.O_MCPU_DO, 8'h00)
        `CHK("rst_q", b1.O_4E_Q, 4'h0)
        `CHK("rst_busy", b1.O_BUSY, 1'b0)
        `CHK("rst_level", b1.O_LEVEL, 3'd0)
        `CHK("rst_ovf", b1.O_OVF, 1'b0)
        `CHK("rst_bad", b1.O_BADPORT, 1'b0)
        rst_n = 1'b1;
        tick();

        // Single command: port 1, data A5 sampled at edge 0
        b1.I_WR = 1'b1; b1.I_PORT = 2'd1; b1.I_DATA = 8'hA5;
        tick();
        b1.I_WR = 1'b0;
        `CHK("e0_level", b1.O_LEVEL, 3'd1)
        `CHK("e0_busy", b1.O_BUSY, 1'b1)
        tick();
        `CHK("e1_do", b1.O_MCPU_DO, 8'hA5)
        `CHK("e1_q", b1.O_4E_Q, 4'h0)
        `CHK("e1_level", b1.O_LEVEL, 3'd0)
        tick();
        `CHK("e2_q", b1.O_4E_Q, 4'h0)
        for (int e = 3; e <= 6; e++) begin
            tick();
            `CHK("e3to6_q", b1.O_4E_Q, 4'b0010)
        end
        tick();
        `CHK("e7_q", b1.O_4E_Q, 4'h0)
        `CHK("e7_do", b1.O_MCPU_DO, 8'hA5)
        tick();
        `CHK("e8_busy", b1.O_BUSY, 1'b1)
        tick();
        `CHK("e9_busy", b1.O_BUSY, 1'b0)
        `CHK("single_cnt", log1.size(), 1)
        `CHK("single_dq", {log1[0].q, log1[0].d}, {4'b0010, 8'hA5})

        // Burst of four consecutive writes
        do_reset();
        pk = 0;
        for (int i = 0; i < 4; i++) begin
            b1.I_WR = 1'b1; b1.I_PORT = bp[i]; b1.I_DATA = bd[i];
            tick();
            if (int'(b1.O_LEVEL) > pk) pk = int'(b1.O_LEVEL);
        end
        b1.I_WR = 1'b0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (int'(b1.O_LEVEL) > pk) pk = int'(b1.O_LEVEL);
        end
        `CHK("burst_cnt", log1.size(), 4)
        for (int i = 0; i < 4; i++) begin
            `CHK("burst_q", log1[i].q, bq[i])
            `CHK("burst_d", log1[i].d, bd[i])
            if (i > 0) `CHK("burst_gap", log1[i].t - log1[i-1].t, 9)
        end
        `CHK("burst_peak", pk, 3)
        `CHK("burst_ovf", b1.O_OVF, 1'b0)
        `CHK("burst_idle", b1.O_BUSY, 1'b0)

        // Overflow: six back-to-back writes, the sixth is dropped
        do_reset();
        for (int i = 0; i < 6; i++) begin
            b1.I_WR = 1'b1; b1.I_PORT = 2'd0; b1.I_DATA = 8'(i + 1);
            tick();
            if (i == 4) `CHK("ovf_full_level", b1.O_LEVEL, 3'd4)
        end
        b1.I_WR = 1'b0;
        `CHK("ovf_flag", b1.O_OVF, 1'b1)
        `CHK("ovf_level", b1.O_LEVEL, 3'd4)
        wait_cyc(60);
        `CHK("ovf_cnt", log1.size(), 5)
        for (int i = 0; i < 5; i++) `CHK("ovf_d", log1[i].d, 8'(i + 1))
        `CHK("ovf_sticky", b1.O_OVF, 1'b1)

        // Bad port write is dropped, a following valid write still goes out
        do_reset();
        b1.I_WR = 1'b1; b1.I_PORT = 2'd3; b1.I_DATA = 8'hFF;
        tick();
        b1.I_WR = 1'b0;
        `CHK("bad_flag", b1.O_BADPORT, 1'b1)
        `CHK("bad_level", b1.O_LEVEL, 3'd0)
        `CHK("bad_busy", b1.O_BUSY, 1'b0)
        wait_cyc(12);
        `CHK("bad_nostrobe", log1.size(), 0)
        b1.I_WR = 1'b1; b1.I_PORT = 2'd2; b1.I_DATA = 8'h5A;
        tick();
        b1.I_WR = 1'b0;
        wait_cyc(12);
        `CHK("bad_next_cnt", log1.size(), 1)
        `CHK("bad_next_dq", {log1[0].q, log1[0].d}, {4'b0100, 8'h5A})
        `CHK("bad_sticky", b1.O_BADPORT, 1'b1)

        // Reset during STROBE with two commands queued
        do_reset();
        for (int i = 0; i < 3; i++) begin
            b1.I_WR = 1'b1; b1.I_PORT = 2'(i); b1.I_DATA = 8'(8'hC0 + i);
            tick();
        end
        b1.I_WR = 1'b0;
        `CHK("mid_level", b1.O_LEVEL, 3'd2)
        wait_cyc(2);
        `CHK("mid_strobe", b1.O_4E_Q, 4'b0001)
        rst_n = 1'b0;
        tick();
        `CHK("mid_q", b1.O_4E_Q, 4'h0)
        `CHK("mid_lvl0", b1.O_LEVEL, 3'd0)
        `CHK("mid_busy", b1.O_BUSY, 1'b0)
        `CHK("mid_flags", {b1.O_OVF, b1.O_BADPORT}, 2'b00)
        rst_n = 1'b1;
        log1.delete();
        wait_cyc(30);
        `CHK("mid_quiet", log1.size(), 0)

        // Minimal timing: 1/1/1 gives a 4-cycle command period
        do_reset();
        b2.I_WR = 1'b1; b2.I_PORT = 2'd0; b2.I_DATA = 8'h77;
        tick();
        b2.I_WR = 1'b0;
        tick();
        `CHK("min_e1_do", b2.O_MCPU_DO, 8'h77)
        `CHK("min_e1_q", b2.O_4E_Q, 4'h0)
        tick();
        `CHK("min_e2_q", b2.O_4E_Q, 4'b0001)
        tick();
        `CHK("min_e3_q", b2.O_4E_Q, 4'h0)
        `CHK("min_e3_do", b2.O_MCPU_DO, 8'h77)
        `CHK("min_e3_busy", b2.O_BUSY, 1'b1)
        tick();
        `CHK("min_e4_busy", b2.O_BUSY, 1'b0)
        log2.delete();
        b2.I_WR = 1'b1; b2.I_PORT = 2'd1; b2.I_DATA = 8'h81;
        tick();
        b2.I_PORT = 2'd2; b2.I_DATA = 8'h82;
        tick();
        b2.I_WR = 1'b0;
        wait_cyc(15);
        `CHK("min_cnt", log2.size(), 2)
        `CHK("min_dq0", {log2[0].q, log2[0].d}, {4'b0010, 8'h81})
        `CHK("min_dq1", {log2[1].q, log2[1].d}, {4'b0100, 8'h82})
        `CHK("min_gap", log2[1].t - log2[0].t, 4)

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
